// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh router datapath.
// Contents:
//   DIR_*            one-hot output-direction codes, bit order {L,W,E,S,N}
//   DEST_X_*/DEST_Y_* destination-coordinate field positions inside a packet
//   PACKET_WIDTH_DEF default packet width
package mesh_pkg;

    localparam int PACKET_WIDTH_DEF = 64;

    typedef logic [4:0] dir_t;

    localparam dir_t DIR_N = 5'b00001;
    localparam dir_t DIR_S = 5'b00010;
    localparam dir_t DIR_E = 5'b00100;
    localparam dir_t DIR_W = 5'b01000;
    localparam dir_t DIR_L = 5'b10000;

    localparam int DEST_X_HI = 55;
    localparam int DEST_X_LO = 52;
    localparam int DEST_Y_HI = 51;
    localparam int DEST_Y_LO = 48;

endpackage

// File: rtl/mesh_input_port_if.sv
// Link and arbiter-facing signals of a mesh input port.
//   link_si/link_di : upstream send strobe and packet
//   link_ri         : ready back to upstream
//   polarity        : link phase driven by the port
//   route_req/gnt   : one-hot request to / grant from the output arbiters
//   pkt_out         : packet held in the outbound virtual channel
// slave  = the input port itself; master = upstream sender plus arbiters.
interface mesh_input_port_if #(
    parameter int PACKET_WIDTH = mesh_pkg::PACKET_WIDTH_DEF
);
    logic                    link_si;
    logic                    link_ri;
    logic [PACKET_WIDTH-1:0] link_di;
    logic                    polarity;
    logic [4:0]              route_req;
    logic [4:0]              route_gnt;
    logic [PACKET_WIDTH-1:0] pkt_out;

    modport master (
        output link_si, link_di, route_gnt,
        input  link_ri, polarity, route_req, pkt_out
    );

    modport slave (
        input  link_si, link_di, route_gnt,
        output link_ri, polarity, route_req, pkt_out
    );
endinterface

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X first, then Y) route decision.
// Ports:
//   dest_x, dest_y : packet destination coordinates (unsigned)
//   dir            : one-hot output direction {L,W,E,S,N}
// Purely combinational; shared by every input port of the router.
module xy_route_calc
    import mesh_pkg::*;
#(
    parameter logic [3:0] MY_X = 4'd0,
    parameter logic [3:0] MY_Y = 4'd0
) (
    input  logic [3:0] dest_x,
    input  logic [3:0] dest_y,
    output dir_t       dir
);
    always_comb begin
        dir = DIR_L;
        if (dest_x > MY_X)      dir = DIR_E;
        else if (dest_x < MY_X) dir = DIR_W;
        else if (dest_y > MY_Y) dir = DIR_N;
        else if (dest_y < MY_Y) dir = DIR_S;
    end
endmodule

// File: rtl/mesh_input_port.sv
// Router receive port terminating one mesh link.
// Two single-entry VC buffers (even/odd) alternate roles every cycle: the
// buffer selected by polarity receives from upstream, the other one presents
// its packet and XY route request to the output arbiters.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   port       : link/arbiter interface (slave side)
//   vc_full    : buffer occupancy {odd,even}
//   rx_count   : accepted-packet counter, wraps at 16 bits
module mesh_input_port
    import mesh_pkg::*;
#(
    parameter int         PACKET_WIDTH = PACKET_WIDTH_DEF,
    parameter logic [3:0] MY_X         = 4'd0,
    parameter logic [3:0] MY_Y         = 4'd0
) (
    input  logic               clk,
    input  logic               reset,
    mesh_input_port_if.slave   port,
    output logic [1:0]         vc_full,
    output logic [15:0]        rx_count
);
    logic                    polarity_q, polarity_d;
    logic [1:0]              full_q, full_d;
    logic [PACKET_WIDTH-1:0] vc_data_q [2];
    logic [PACKET_WIDTH-1:0] vc_data_d [2];
    logic [15:0]             rx_count_q, rx_count_d;

    logic                    out_vc;
    logic [PACKET_WIDTH-1:0] out_pkt;
    dir_t                    route_dir;
    logic                    accept;
    logic                    release_vc;

    // Outbound VC is always the one upstream cannot write this cycle.
    assign out_vc  = ~polarity_q;
    assign out_pkt = vc_data_q[out_vc];

    xy_route_calc #(
        .MY_X (MY_X),
        .MY_Y (MY_Y)
    ) u_route (
        .dest_x (out_pkt[DEST_X_HI:DEST_X_LO]),
        .dest_y (out_pkt[DEST_Y_HI:DEST_Y_LO]),
        .dir    (route_dir)
    );

    always_comb begin
        port.link_ri   = ~full_q[polarity_q];
        port.polarity  = polarity_q;
        port.route_req = full_q[out_vc] ? route_dir : '0;
        port.pkt_out   = full_q[out_vc] ? out_pkt : '0;
        vc_full        = full_q;
        rx_count       = rx_count_q;
    end

    always_comb begin
        accept     = port.link_si & ~full_q[polarity_q];
        // Only grant bits that match the live request release the buffer.
        release_vc = |(port.route_gnt & port.route_req);

        polarity_d = ~polarity_q;
        full_d     = full_q;
        vc_data_d  = vc_data_q;
        rx_count_d = rx_count_q;

        if (accept) begin
            vc_data_d[polarity_q] = port.link_di;
            full_d[polarity_q]    = 1'b1;
            rx_count_d            = rx_count_q + 16'd1;
        end
        // Accept and release always address different buffers.
        if (release_vc) begin
            vc_data_d[out_vc] = '0;
            full_d[out_vc]    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity_q   <= 1'b0;
            full_q       <= 2'b00;
            vc_data_q[0] <= '0;
            vc_data_q[1] <= '0;
            rx_count_q   <= 16'd0;
        end else begin
            polarity_q   <= polarity_d;
            full_q       <= full_d;
            vc_data_q[0] <= vc_data_d[0];
            vc_data_q[1] <= vc_data_d[1];
            rx_count_q   <= rx_count_d;
        end
    end
endmodule

// File: tb/tb_mesh_input_port.sv
// Testbench for mesh_input_port (MY_X=1, MY_Y=1).
module tb_mesh_input_port;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  vc_full;
    logic [15:0] rx_count;

    int nvec = 0;
    int nmis = 0;

    mesh_input_port_if #(.PACKET_WIDTH(64)) port_if ();

    mesh_input_port #(
        .PACKET_WIDTH (64),
        .MY_X         (4'd1),
        .MY_Y         (4'd1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .port     (port_if.slave),
        .vc_full  (vc_full),
        .rx_count (rx_count)
    );

    always #5 clk = ~clk;

    // Reference model: two packet slots with occupancy flags, a phase bit, a count.
    logic        m_pol;
    logic        m_full [2];
    logic [63:0] m_pkt  [2];
    int          m_cnt;

    logic        cur_si;
    logic [63:0] cur_di;
    logic [4:0]  cur_gnt;

    function automatic logic [4:0] exp_route(input logic [63:0] p);
        int dx, dy;
        dx = int'(p[55:52]);
        dy = int'(p[51:48]);
        if (dx > 1) return 5'b00100;
        if (dx < 1) return 5'b01000;
        if (dy > 1) return 5'b00001;
        if (dy < 1) return 5'b00010;
        return 5'b10000;
    endfunction

    task automatic model_reset();
        m_pol = 1'b0;
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_pkt[0] = '0;    m_pkt[1] = '0;
        m_cnt = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic        e_ri, ob;
        logic [4:0]  e_req;
        logic [63:0] e_pkt;
        ob    = ~m_pol;
        e_ri  = ~m_full[m_pol];
        e_req = m_full[ob] ? exp_route(m_pkt[ob]) : 5'b0;
        e_pkt = m_full[ob] ? m_pkt[ob] : 64'b0;
        nvec++;
        if (port_if.link_ri !== e_ri || port_if.polarity !== m_pol ||
            vc_full !== {m_full[1], m_full[0]} || rx_count !== 16'(m_cnt) ||
            port_if.route_req !== e_req || port_if.pkt_out !== e_pkt) begin
            nmis++;
            $display("FAIL model t=%0t ri=%b/%b pol=%b/%b full=%b/%b cnt=%h/%h req=%b/%b pkt=%h/%h",
                     $time, port_if.link_ri, e_ri, port_if.polarity, m_pol,
                     vc_full, {m_full[1], m_full[0]}, rx_count, 16'(m_cnt),
                     port_if.route_req, e_req, port_if.pkt_out, e_pkt);
        end
    endtask

    // Called at a negedge: drive inputs, then compare against the model.
    task automatic step_pre(input logic si, input logic [63:0] di, input logic [4:0] gnt);
        cur_si = si; cur_di = di; cur_gnt = gnt;
        port_if.link_si   = si;
        port_if.link_di   = di;
        port_if.route_gnt = gnt;
        #1;
        check_model();
    endtask

    // Advance through the rising edge, apply the rules to the model, stop at next negedge.
    task automatic step_post();
        logic ob, acc, rel;
        @(posedge clk);
        ob  = ~m_pol;
        acc = cur_si && !m_full[m_pol];
        rel = m_full[ob] && ((cur_gnt & exp_route(m_pkt[ob])) != 5'b0);
        if (acc) begin
            m_pkt[m_pol] = cur_di;
            m_full[m_pol] = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (rel) begin
            m_pkt[ob] = '0;
            m_full[ob] = 1'b0;
        end
        m_pol = ~m_pol;
        @(negedge clk);
    endtask

    task automatic step(input logic si, input logic [63:0] di, input logic [4:0] gnt);
        step_pre(si, di, gnt);
        step_post();
    endtask

    task automatic wait_pol(input logic p);
        if (m_pol != p) step(1'b0, 64'h0, 5'h0);
    endtask

    typedef struct {
        logic [63:0] pkt;
        logic [4:0]  gnt;
        logic [4:0]  exp_req;
        logic        exp_held;
    } route_vec_t;

    route_vec_t tv [7];

    initial begin
        int c0;
        int guard;
        tv[0] = '{64'h0021_0000_0000_0001, 5'b00100, 5'b00100, 1'b0}; // east, granted
        tv[1] = '{64'h0011_0000_0000_0002, 5'b10000, 5'b10000, 1'b0}; // local
        tv[2] = '{64'h0010_0000_0000_0003, 5'b00001, 5'b00010, 1'b1}; // south, wrong grant
        tv[3] = '{64'h0001_0000_0000_0004, 5'b01000, 5'b01000, 1'b0}; // west
        tv[4] = '{64'h0012_0000_0000_0005, 5'b11111, 5'b00001, 1'b0}; // north
        tv[5] = '{64'hAAF3_5555_1234_5678, 5'b00100, 5'b00100, 1'b0}; // east, upper bits pass through
        tv[6] = '{64'h0000_0000_0000_0006, 5'b00000, 5'b01000, 1'b1}; // west, no grant

        port_if.link_si = 1'b0;
        port_if.link_di = '0;
        port_if.route_gnt = '0;
        cur_si = 1'b0; cur_di = '0; cur_gnt = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        check_model();
        chk("reset_ri", 64'(port_if.link_ri), 64'd1);
        chk("reset_req", 64'(port_if.route_req), 64'd0);
        reset = 1'b1;

        // Polarity sequence after release
        step_pre(1'b0, 64'h0, 5'h0); chk("pol0", 64'(port_if.polarity), 64'd0); step_post();
        step_pre(1'b0, 64'h0, 5'h0); chk("pol1", 64'(port_if.polarity), 64'd1); step_post();
        step_pre(1'b0, 64'h0, 5'h0); chk("pol2", 64'(port_if.polarity), 64'd0); step_post();

        // Routing table through the even VC
        for (int i = 0; i < 7; i++) begin
            wait_pol(1'b0);
            step(1'b1, tv[i].pkt, 5'h0);
            step_pre(1'b0, 64'h0, tv[i].gnt);
            chk($sformatf("route_req[%0d]", i), 64'(port_if.route_req), 64'(tv[i].exp_req));
            chk($sformatf("pkt_out[%0d]", i), port_if.pkt_out, tv[i].pkt);
            step_post();
            chk($sformatf("held[%0d]", i), 64'(vc_full[0]), 64'(tv[i].exp_held));
            if (tv[i].exp_held) begin
                wait_pol(1'b1);
                step(1'b0, 64'h0, 5'h1F);
            end
        end

        // Backpressure: even VC held without grant
        wait_pol(1'b0);
        step(1'b1, 64'h0021_0000_0000_00A0, 5'h0);
        c0 = m_cnt;
        for (int i = 0; i < 8; i++) begin
            step_pre(1'b1, {32'h0001_0000, $urandom}, 5'h0);
            if (m_pol == 1'b0) chk("bp_ri", 64'(port_if.link_ri), 64'd0);
            step_post();
        end
        chk("bp_full", 64'(vc_full), 64'd3);
        chk("bp_count", 64'(rx_count), 64'((c0 + 1) % 65536));

        // Reset mid-traffic with both VCs occupied
        reset = 1'b0;
        #1;
        chk("mid_rst_ri", 64'(port_if.link_ri), 64'd1);
        chk("mid_rst_full", 64'(vc_full), 64'd0);
        chk("mid_rst_cnt", 64'(rx_count), 64'd0);
        chk("mid_rst_req", 64'(port_if.route_req), 64'd0);
        chk("mid_rst_pkt", port_if.pkt_out, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step_pre(1'b0, 64'h0, 5'h0); chk("mid_rst_pol", 64'(port_if.polarity), 64'd0); step_post();

        // Concurrent accept into even with release of odd
        wait_pol(1'b1);
        step(1'b1, 64'h0001_0000_0000_00B1, 5'h0);
        c0 = m_cnt;
        step_pre(1'b1, 64'h0011_0000_0000_00C2, 5'h1F);
        chk("conc_before", 64'(vc_full), 64'd2);
        step_post();
        chk("conc_after", 64'(vc_full), 64'd1);
        chk("conc_count", 64'(rx_count), 64'((c0 + 1) % 65536));
        step(1'b0, 64'h0, 5'h1F);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [4:0] g;
            g = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'h0;
            step(1'($urandom), {$urandom, $urandom}, g);
        end

        // Counter wrap: stream continuously with every request granted
        guard = 0;
        while (m_cnt != 65535 && guard < 70000) begin
            step(1'b1, {$urandom, $urandom}, 5'h1F);
            guard++;
        end
        chk("wrap_pre", 64'(rx_count), 64'hFFFF);
        if (m_full[m_pol]) step(1'b0, 64'h0, 5'h1F);
        step(1'b1, 64'h0011_0000_0000_0000, 5'h1F);
        chk("wrap_post", 64'(rx_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
